// File: rtl/scrub_mon_poller_pkg.sv
// Shared types and constants for the scrub monitor poller: FSM states,
// monitor register addresses and counter sizing.
package scrub_mon_poller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_IRQ,
    RD_CYC,
    GAP,
    UPDATE
  } state_t;

  localparam int unsigned ADDR_IRQ = 0;
  localparam int unsigned ADDR_CYC = 1;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/scrub_mon_poller_counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module scrub_mon_poller_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + 1'b1;
  end

endmodule

// File: rtl/scrub_mon_poller.sv
// Periodically reads the scrub monitor IRQ and cycles-per-bit-flip registers
// over REG_BUS and raises sticky alarm / bus-error / timeout flags.
module scrub_mon_poller
  import scrub_mon_poller_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int POLL_PERIOD    = 1000,
  parameter int TIMEOUT        = 64,
  parameter int BF_THRESH      = 100
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  output logic [BUS_ADDR_WIDTH-1:0] reg_addr_o,
  output logic                      reg_write_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb_o,
  output logic                      reg_valid_o,
  input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
  input  logic                      reg_ready_i,
  input  logic                      reg_error_i,
  output logic                      irq_flag_o,
  output logic [DATA_WIDTH-1:0]     cyc_per_bf_o,
  output logic                      sample_valid_o,
  output logic                      alarm_o,
  output logic                      bus_err_o,
  output logic                      timeout_o,
  output logic                      busy_o
);

  localparam int PW = cnt_w(POLL_PERIOD);
  localparam int TW = cnt_w(TIMEOUT);

  state_t                state, state_next;
  logic                  gap_cyc, gap_cyc_next;  // GAP leads on to RD_CYC rather than IDLE
  logic                  hold_irq;
  logic [DATA_WIDTH-1:0] hold_cyc;
  logic [PW-1:0]         per_cnt;
  logic [TW-1:0]         wait_cnt;
  logic                  in_rd, done, expire, go;
  logic                  set_alarm, set_berr, set_tmo;

  assign in_rd  = (state == RD_IRQ) || (state == RD_CYC);
  assign done   = in_rd && (reg_ready_i || reg_error_i);
  assign expire = in_rd && !done && (wait_cnt == TW'(TIMEOUT - 1));
  assign go     = (state == IDLE) &&
                  (start_i || (enable_i && per_cnt == PW'(POLL_PERIOD - 1)));

  scrub_mon_poller_counter #(.WIDTH(PW)) u_period (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (!enable_i || state != IDLE || go),
    .enable (1'b1),
    .count  (per_cnt)
  );

  scrub_mon_poller_counter #(.WIDTH(TW)) u_wait (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (!in_rd || done || expire),
    .enable (1'b1),
    .count  (wait_cnt)
  );

  always_comb begin
    state_next   = state;
    gap_cyc_next = gap_cyc;
    case (state)
      IDLE: if (go) state_next = RD_IRQ;
      RD_IRQ, RD_CYC: begin
        // error takes precedence over ready when both are seen
        if (reg_error_i) begin
          state_next   = GAP;
          gap_cyc_next = 1'b0;
        end else if (reg_ready_i) begin
          if (state == RD_IRQ) begin
            state_next   = GAP;
            gap_cyc_next = 1'b1;
          end else begin
            state_next = UPDATE;
          end
        end else if (expire) begin
          state_next   = GAP;
          gap_cyc_next = 1'b0;
        end
      end
      GAP:     state_next = gap_cyc ? RD_CYC : IDLE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign set_alarm = (state == UPDATE) &&
                     (hold_irq || (hold_cyc != '0 && hold_cyc < DATA_WIDTH'(BF_THRESH)));
  assign set_berr  = in_rd && reg_error_i;
  assign set_tmo   = expire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      gap_cyc      <= 1'b0;
      hold_irq     <= 1'b0;
      hold_cyc     <= '0;
      irq_flag_o   <= 1'b0;
      cyc_per_bf_o <= '0;
      alarm_o      <= 1'b0;
      bus_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cyc <= gap_cyc_next;
      if (state == RD_IRQ && reg_ready_i && !reg_error_i) hold_irq <= reg_rdata_i[0];
      if (state == RD_CYC && reg_ready_i && !reg_error_i) hold_cyc <= reg_rdata_i;
      // outputs only move as a pair, once both reads have succeeded
      if (state == UPDATE) begin
        irq_flag_o   <= hold_irq;
        cyc_per_bf_o <= hold_cyc;
      end
      alarm_o   <= (alarm_o   && !clear_i) || set_alarm;
      bus_err_o <= (bus_err_o && !clear_i) || set_berr;
      timeout_o <= (timeout_o && !clear_i) || set_tmo;
    end
  end

  assign reg_valid_o    = in_rd;
  assign reg_addr_o     = (state == RD_CYC) ? BUS_ADDR_WIDTH'(ADDR_CYC) : BUS_ADDR_WIDTH'(ADDR_IRQ);
  assign reg_write_o    = 1'b0;
  assign reg_wdata_o    = '0;
  assign reg_wstrb_o    = '0;
  assign sample_valid_o = (state == UPDATE);
  assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_scrub_mon_poller.sv
// Directed and randomized bench for scrub_mon_poller with a transaction-level
// bus model checked every cycle.
module tb_scrub_mon_poller;
  localparam int AW = 8, DW = 32, PP = 10, TO = 8, BF = 100;

  logic clk = 1'b0;
  logic rst, enable, start, clear;
  logic [AW-1:0] addr;
  logic write, valid, ready, err;
  logic [DW-1:0] wdata, rdata, cyc;
  logic [DW/8-1:0] wstrb;
  logic irq, sv, alarm, berr, tmo, busy;

  scrub_mon_poller #(.BUS_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_PERIOD(PP),
                     .TIMEOUT(TO), .BF_THRESH(BF)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_i(start), .clear_i(clear),
    .reg_addr_o(addr), .reg_write_o(write), .reg_wdata_o(wdata), .reg_wstrb_o(wstrb),
    .reg_valid_o(valid), .reg_rdata_i(rdata), .reg_ready_i(ready), .reg_error_i(err),
    .irq_flag_o(irq), .cyc_per_bf_o(cyc), .sample_valid_o(sv), .alarm_o(alarm),
    .bus_err_o(berr), .timeout_o(tmo), .busy_o(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // responder configuration: rmode 0 = answer next cycle, 1 = random latency, 2 = silent
  int rmode = 0, err_addr = -1, err_pct = 0;
  bit rand_data = 0;
  logic [DW-1:0] d0_src = '0, d1_src = '0;

  // outputs of the most recently completed cycle, as seen by the driver
  logic s_valid, s_ready, s_err, s_sv, s_irq, s_alarm, s_berr, s_tmo, s_busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_cyc;
  int cyc_no = 0, last_start = 0, prev_start = 0, t_sv = 0;
  logic pv_t = 1'b0;

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(3, 0))
      0:       return '0;
      1, 2:    return DW'($urandom_range(200, 1));
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic tick(input logic st, input logic clr, input logic rs);
    bit resp;
    @(negedge clk);
    s_valid = valid; s_ready = ready; s_err = err; s_addr = addr; s_sv = sv;
    s_irq = irq; s_cyc = cyc; s_alarm = alarm; s_berr = berr; s_tmo = tmo; s_busy = busy;
    cyc_no++;
    if (s_valid && !pv_t && s_addr == 0) begin prev_start = last_start; last_start = cyc_no; end
    if (s_sv) t_sv = cyc_no;
    pv_t = s_valid;
    @(posedge clk); #1;
    ready = 1'b0; err = 1'b0; rdata = DW'($urandom);
    if (s_valid && !s_ready && !s_err) begin
      resp = (rmode == 0) || (rmode == 1 && $urandom_range(1, 0) == 1);
      if (resp) begin
        ready = 1'b1;
        rdata = rand_data ? rnd_val() : ((s_addr == 0) ? d0_src : d1_src);
        if (err_addr == int'(s_addr)) begin ready = 1'b0; err = 1'b1; end
        if (err_pct > 0 && $urandom_range(99, 0) < err_pct) begin
          err = 1'b1; ready = $urandom_range(1, 0) == 1;
        end
      end
    end
    start = st; clear = clr; rst = rs;
  endtask

  task automatic wait_sv(input int maxc);
    int n = 0;
    do begin tick(0, 0, 0); n++; end while (!s_sv && n < maxc);
    chk("sample_wait", s_sv, 1);
  endtask

  task automatic run_poll(input int maxc, output int nsv, output int nval);
    bit seen = 0;
    int n = 0;
    nsv = 0; nval = 0;
    tick(1, 0, 0);
    do begin
      tick(0, 0, 0); n++;
      if (s_busy) seen = 1;
      if (s_sv) nsv++;
      if (s_valid) nval++;
    end while (!(seen && !s_busy) && n < maxc);
    chk("poll_end_idle", s_busy, 0);
  endtask

  // Transaction-level model: tracks bus handshakes and what the outputs must show.
  initial begin : model
    logic m_alarm, m_berr, m_tmo, m_irq, m_pend, m_gap, m_next_cyc, m_pv;
    logic [DW-1:0] m_cyc, m_d0, m_d1;
    logic [AW-1:0] m_pa;
    logic compl, set_al, set_be, set_to, new_pend;
    int m_wait;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_alarm = 0; m_berr = 0; m_tmo = 0; m_irq = 0; m_cyc = '0; m_d0 = '0; m_d1 = '0;
        m_pend = 0; m_gap = 0; m_next_cyc = 0; m_pv = 0; m_pa = '0; m_wait = 0;
      end else begin
        chk("tied_write", {write, wdata, wstrb}, 0);
        chk("alarm", alarm, m_alarm);
        chk("bus_err", berr, m_berr);
        chk("timeout", tmo, m_tmo);
        chk("irq_flag", irq, m_irq);
        chk("cyc_per_bf", cyc, m_cyc);
        chk("sample_valid", sv, m_pend);
        if (m_gap) chk("gap_valid_low", valid, 0);
        if (valid || m_pend) chk("busy", busy, 1);
        if (valid && m_pv) chk("addr_stable", addr, m_pa);
        if (valid && !m_pv) chk("req_addr", addr, AW'(m_next_cyc));

        compl  = valid && (ready || err);
        set_al = m_pend && (m_d0[0] || (m_d1 != 0 && m_d1 < BF));
        if (m_pend) begin m_irq = m_d0[0]; m_cyc = m_d1; end
        set_be = compl && err;
        set_to = 0;
        new_pend = compl && !err && addr == 1;
        if (compl && !err) begin
          if (addr == 0) begin m_d0 = rdata; m_next_cyc = 1; end
          else begin m_d1 = rdata; m_next_cyc = 0; end
        end
        if (set_be) m_next_cyc = 0;
        if (valid && !compl) begin
          m_wait++;
          if (m_wait == TO) begin set_to = 1; m_wait = 0; m_next_cyc = 0; end
        end else m_wait = 0;
        m_gap   = compl || set_to;
        m_alarm = (m_alarm && !clear) || set_al;
        m_berr  = (m_berr && !clear) || set_be;
        m_tmo   = (m_tmo && !clear) || set_to;
        m_pend  = new_pend;
        m_pv    = valid;
        m_pa    = addr;
      end
    end
  end

  initial begin
    int nsv, nval, extra;
    rst = 1; enable = 0; start = 0; clear = 0; ready = 0; err = 0; rdata = '0;
    repeat (3) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_outs", {s_irq, s_cyc, s_alarm, s_berr, s_tmo, s_sv}, 0);

    // periodic polling, registered-ready responder
    d0_src = 32'h1; d1_src = 32'h200; enable = 1;
    wait_sv(60);
    chk("poll_len", t_sv - last_start, 5);
    tick(0, 0, 0);
    chk("p1_irq", s_irq, 1);
    chk("p1_cyc", s_cyc, 32'h200);
    chk("p1_alarm", s_alarm, 1);
    wait_sv(60);
    chk("period", last_start - prev_start, PP + 6);
    enable = 0;
    tick(0, 0, 0);

    // threshold rule
    tick(0, 1, 0);
    d0_src = 0; d1_src = 50;
    run_poll(30, nsv, nval);
    chk("thr_alarm", s_alarm, 1);
    chk("thr_cyc", s_cyc, 50);
    chk("thr_irq", s_irq, 0);
    tick(0, 1, 0);
    d1_src = 0;
    run_poll(30, nsv, nval);
    chk("zero_alarm", s_alarm, 0);
    chk("zero_cyc", s_cyc, 0);

    // start while disabled: exactly one poll
    run_poll(30, nsv, nval);
    extra = 0;
    repeat (40) begin tick(0, 0, 0); if (s_sv) extra++; end
    chk("one_poll_sv", nsv + extra, 1);
    chk("one_poll_reads", nval, 4);

    // clear coinciding with an alarming UPDATE
    d0_src = 1;
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("upd_cycle", s_sv, 1);
    tick(0, 0, 0);
    chk("clear_vs_set", s_alarm, 1);

    // bus error on the second read
    d0_src = 0; d1_src = 300;
    run_poll(30, nsv, nval);
    err_addr = 1; d1_src = 77;
    run_poll(30, nsv, nval);
    chk("err_no_sample", nsv, 0);
    chk("err_flag", s_berr, 1);
    chk("err_cyc_held", s_cyc, 300);
    err_addr = -1; d0_src = 1; d1_src = 32'h500;
    run_poll(30, nsv, nval);
    chk("after_err_sample", nsv, 1);
    chk("after_err_cyc", s_cyc, 32'h500);

    // silent responder
    rmode = 2;
    run_poll(40, nsv, nval);
    chk("tmo_valid_cycles", nval, TO);
    chk("tmo_flag", s_tmo, 1);
    chk("tmo_no_sample", nsv, 0);
    chk("tmo_cyc_held", s_cyc, 32'h500);
    rmode = 0;

    // reset during the second read
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    chk("in_rd_cyc", {s_valid, s_addr}, {1'b1, 8'd1});
    tick(0, 0, 0);
    chk("rst_mid_valid", s_valid, 0);
    chk("rst_mid_busy", s_busy, 0);
    chk("rst_mid_outs", {s_irq, s_cyc, s_alarm, s_berr, s_tmo, s_sv}, 0);

    // randomized traffic
    rand_data = 1;
    for (int b = 0; b < 20; b++) begin
      int m;
      m = $urandom_range(5, 0);
      rmode = (m == 5) ? 2 : ((m >= 3) ? 1 : 0);
      err_pct = ($urandom_range(1, 0) == 1) ? 10 : 0;
      enable = $urandom_range(3, 0) != 0;
      for (int i = 0; i < 150; i++)
        tick($urandom_range(19, 0) == 0, $urandom_range(39, 0) == 0, $urandom_range(499, 0) == 0);
    end
    tick(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
